// File: rtl/board_input_filter_if.sv
// ---------------------------------------------------------------------------
// board_input_filter_if
//   Bundles the raw board inputs and the conditioned outputs of
//   board_input_filter.
//   raw_in    : asynchronous raw button/switch levels (N_IN bits)
//   level_out : debounced level per bit
//   rise_out  : one-cycle pulse after a debounced 0->1 transition
//   fall_out  : one-cycle pulse after a debounced 1->0 transition
//   run       : run/stop toggle flag
//   master : board / testbench side (drives raw_in)
//   slave  : filter side (drives the conditioned outputs)
// ---------------------------------------------------------------------------
interface board_input_filter_if #(
  parameter int N_IN = 12
);
  logic [N_IN-1:0] raw_in;
  logic [N_IN-1:0] level_out;
  logic [N_IN-1:0] rise_out;
  logic [N_IN-1:0] fall_out;
  logic            run;

  modport master (
    output raw_in,
    input  level_out,
    input  rise_out,
    input  fall_out,
    input  run
  );

  modport slave (
    input  raw_in,
    output level_out,
    output rise_out,
    output fall_out,
    output run
  );
endinterface

// File: rtl/board_input_filter.sv
// ---------------------------------------------------------------------------
// board_input_filter
//   Conditions the raw board inputs (stop button, Debug_DM button, slide
//   switches) before they reach the CPU wrapper: per-bit 2-flop
//   synchroniser, per-bit debounce counter, registered rise/fall pulses,
//   and a run/stop flag toggled by the debounced rising edge of RUN_BIT.
//   Ports:
//     clk : board clock, all state updates on its rising edge
//     rst : synchronous active-high reset
//     bus : slave side of board_input_filter_if (raw_in in; level_out,
//           rise_out, fall_out, run out). Every output is a register.
// ---------------------------------------------------------------------------
module board_input_filter #(
  parameter int   N_IN      = 12,
  parameter int   DB_CYCLES = 1000000,
  parameter int   CNT_W     = 20,
  parameter int   RUN_BIT   = 11,
  parameter logic RUN_RST   = 1'b0
) (
  input logic                 clk,
  input logic                 rst,
  board_input_filter_if.slave bus
);

  // A new value is accepted on the edge where the counter has already
  // seen DB_CYCLES-1 disagreeing cycles, i.e. on the DB_CYCLES-th one.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [N_IN-1:0] sync1_reg;
  logic [N_IN-1:0] sync2_reg;
  logic [N_IN-1:0] level_reg;
  logic [N_IN-1:0] level_next;
  logic [N_IN-1:0] level_d_reg;
  logic [N_IN-1:0] rise_reg;
  logic [N_IN-1:0] fall_reg;
  logic            run_reg;

  // Two-flop synchroniser; only sync2 is allowed into the debounce logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= bus.raw_in;
      sync2_reg <= sync1_reg;
    end
  end

  // Per-bit debounce counter. Any cycle of agreement clears the count, so
  // only an uninterrupted run of DB_CYCLES disagreeing cycles is accepted.
  generate
    for (genvar gi = 0; gi < N_IN; gi++) begin : g_db
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;
      logic             level_bit_next;

      always_comb begin
        cnt_next       = '0;
        level_bit_next = level_reg[gi];
        if (sync2_reg[gi] != level_reg[gi]) begin
          if (cnt_reg == CNT_MAX) begin
            level_bit_next = sync2_reg[gi];
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end

      assign level_next[gi] = level_bit_next;
    end
  endgenerate

  // Debounced level plus a one-cycle-delayed copy; the pulses are formed
  // from the registered level, so they appear the cycle after it changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_reg   <= '0;
      level_d_reg <= '0;
      rise_reg    <= '0;
      fall_reg    <= '0;
      run_reg     <= RUN_RST;
    end else begin
      level_reg   <= level_next;
      level_d_reg <= level_reg;
      rise_reg    <= level_reg & ~level_d_reg;
      fall_reg    <= ~level_reg & level_d_reg;
      // A held button yields a single rise pulse, hence a single toggle.
      run_reg     <= run_reg ^ rise_reg[RUN_BIT];
    end
  end

  assign bus.level_out = level_reg;
  assign bus.rise_out  = rise_reg;
  assign bus.fall_out  = fall_reg;
  assign bus.run       = run_reg;

endmodule

// File: tb/tb_board_input_filter.sv
// ---------------------------------------------------------------------------
// tb_board_input_filter
//   Directed test of board_input_filter with DB_CYCLES=4. Edge numbering:
//   raw_in changes just before edge 0; outputs are sampled on the falling
//   edge after each rising edge. With DB_CYCLES=4 a held change shows on
//   level_out after edge 5, the matching pulse after edge 6 only, and a
//   RUN_BIT rise toggles run after edge 7.
// ---------------------------------------------------------------------------
module tb_board_input_filter;
  localparam int N = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  board_input_filter_if #(.N_IN(N)) bus ();

  board_input_filter #(
    .N_IN      (N),
    .DB_CYCLES (4),
    .CNT_W     (20),
    .RUN_BIT   (11),
    .RUN_RST   (1'b0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag, input int e, input logic [11:0] lvl,
                           input logic [11:0] rise, input logic [11:0] fall, input logic run_exp);
    $display("%s e=%0d level=%h rise=%h fall=%h run=%b", tag, e,
             bus.level_out, bus.rise_out, bus.fall_out, bus.run);
    check({tag, "_level"}, bus.level_out, lvl);
    check({tag, "_rise"}, bus.rise_out, rise);
    check({tag, "_fall"}, bus.fall_out, fall);
    check({tag, "_run"}, {11'd0, bus.run}, {11'd0, run_exp});
  endtask

  // raw_in has just been changed on the bits in m (caller set it); follow
  // the next n edges with hand-derived expectations.
  task automatic expect_edge(input string tag, input logic [11:0] m, input logic up,
                             input logic [11:0] lvl0, input logic [11:0] lvl1,
                             input logic run0, input logic run1, input int n);
    for (int e = 0; e < n; e++) begin
      tick();
      check_all(tag, e,
                (e >= 5) ? lvl1 : lvl0,
                (e == 6 && up)  ? m : 12'h000,
                (e == 6 && !up) ? m : 12'h000,
                (e >= 7) ? run1 : run0);
    end
  endtask

  initial begin
    bus.raw_in = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Idle after reset
    for (int e = 0; e < 5; e++) begin
      tick();
      check_all("idle", e, 12'h000, 12'h000, 12'h000, 1'b0);
    end

    // Bit 3 rises and later falls
    bus.raw_in = 12'h008;
    expect_edge("b3_up", 12'h008, 1'b1, 12'h000, 12'h008, 1'b0, 1'b0, 9);
    bus.raw_in = 12'h000;
    expect_edge("b3_dn", 12'h008, 1'b0, 12'h008, 12'h000, 1'b0, 1'b0, 9);

    // Bit 5: 3-cycle pulse is rejected
    for (int e = 0; e < 14; e++) begin
      bus.raw_in = (e < 3) ? 12'h020 : 12'h000;
      tick();
      check_all("glitch3", e, 12'h000, 12'h000, 12'h000, 1'b0);
    end

    // Bit 5: 4-cycle pulse is accepted, then falls after 4 low cycles
    for (int e = 0; e < 14; e++) begin
      bus.raw_in = (e < 4) ? 12'h020 : 12'h000;
      tick();
      check_all("pulse4", e,
                (e >= 5 && e < 9) ? 12'h020 : 12'h000,
                (e == 6)  ? 12'h020 : 12'h000,
                (e == 10) ? 12'h020 : 12'h000,
                1'b0);
    end

    // Run button: press (20 cycles) / release / press / release
    bus.raw_in = 12'h800;
    expect_edge("run_p1", 12'h800, 1'b1, 12'h000, 12'h800, 1'b0, 1'b1, 20);
    bus.raw_in = 12'h000;
    expect_edge("run_r1", 12'h800, 1'b0, 12'h800, 12'h000, 1'b1, 1'b1, 10);
    bus.raw_in = 12'h800;
    expect_edge("run_p2", 12'h800, 1'b1, 12'h000, 12'h800, 1'b1, 1'b0, 20);
    bus.raw_in = 12'h000;
    expect_edge("run_r2", 12'h800, 1'b0, 12'h800, 12'h000, 1'b0, 1'b0, 10);
    bus.raw_in = 12'h800;
    expect_edge("run_p3", 12'h800, 1'b1, 12'h000, 12'h800, 1'b0, 1'b1, 12);
    bus.raw_in = 12'h000;
    expect_edge("run_r3", 12'h800, 1'b0, 12'h800, 12'h000, 1'b1, 1'b1, 10);

    // Reset in the middle of a debounce count with run=1
    bus.raw_in = 12'h800;
    tick();
    tick();
    tick();
    check_all("mid_cnt", 2, 12'h000, 12'h000, 12'h000, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all("mid_rst", 0, 12'h000, 12'h000, 12'h000, 1'b0);
    expect_edge("post_rst", 12'h800, 1'b1, 12'h000, 12'h800, 1'b0, 1'b1, 10);

    // All bits at once from a fresh reset
    bus.raw_in = 12'h000;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all("rst2", 0, 12'h000, 12'h000, 12'h000, 1'b0);
    bus.raw_in = 12'hFFF;
    expect_edge("all", 12'hFFF, 1'b1, 12'h000, 12'hFFF, 1'b0, 1'b1, 10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
